vga_timing_gen: RTL

- Parametrised VGA raster timing generator: programmable resolution, porches and sync polarity, integer pixel-clock divider, pixel coordinates and frame/line markers.
- Sits between the system Clock and the pixel/colour logic inside the MiniAlu top level, which drives VGA_RED/GREEN/BLUE from oX/oY/oVisible.
- Generalises the team's fixed 640x480 sync logic so other modes and pixel rates need only new parameters.

---
 rtl/vga_timing_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised VGA raster timing (sync, coordinates, markers)
// Rev 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           iEnable,
    output logic           oPixelTick,
    output logic           oHSync,
    output logic           oVSync,
    output logic           oVisible,
    output logic [X_W-1:0] oX,
    output logic [Y_W-1:0] oY,
    output logic           oLineStart,
    output logic           oFrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (CLK_DIV < 1 || H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
            (H_TOTAL - 1) >= (1 << X_W) || (V_TOTAL - 1) >= (1 << Y_W)) begin : g_param_check
            $error("vga_timing_gen: unsupported parameter set");
        end
    endgenerate

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   H_FP_BEG = X_W'(H_VISIBLE);
    localparam logic [X_W-1:0]   H_SY_BEG = X_W'(H_VISIBLE + H_FRONT);
    localparam logic [X_W-1:0]   H_BP_BEG = X_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_FP_BEG = Y_W'(V_VISIBLE);
    localparam logic [Y_W-1:0]   V_SY_BEG = Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W-1:0]   V_BP_BEG = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {H_ACT = 2'd0, H_FP = 2'd1, H_SY = 2'd2, H_BP = 2'd3} h_state_t;
    typedef enum logic [1:0] {V_ACT = 2'd0, V_FP = 2'd1, V_SY = 2'd2, V_BP = 2'd3} v_state_t;

    h_state_t         h_state;
    v_state_t         v_state;
    logic             tick;
    logic             h_wrap;

    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0]   hcnt_q, hcnt_d;
    logic [Y_W-1:0]   vcnt_q, vcnt_d;
    logic             pix_tick_q, pix_tick_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             visible_q, visible_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Raster state is decoded from the next counter values so that every
    // registered output describes the same pixel as the counters.
    always_comb begin
        tick          = (div_q == DIV_LAST);
        h_wrap        = (hcnt_q == H_LAST);
        div_d         = div_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        pix_tick_d    = 1'b0;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        visible_d     = visible_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_state       = H_ACT;
        v_state       = V_ACT;

        if (!iEnable) begin
            div_d     = '0;
            hcnt_d    = '0;
            vcnt_d    = '0;
            hsync_d   = ~HSYNC_POL;
            vsync_d   = ~VSYNC_POL;
            visible_d = 1'b0;
            x_d       = '0;
            y_d       = '0;
        end else if (tick) begin
            div_d  = '0;
            hcnt_d = h_wrap ? '0 : hcnt_q + X_W'(1);
            if (h_wrap) begin
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + Y_W'(1);
            end

            if (hcnt_d < H_FP_BEG)      h_state = H_ACT;
            else if (hcnt_d < H_SY_BEG) h_state = H_FP;
            else if (hcnt_d < H_BP_BEG) h_state = H_SY;
            else                        h_state = H_BP;

            if (vcnt_d < V_FP_BEG)      v_state = V_ACT;
            else if (vcnt_d < V_SY_BEG) v_state = V_FP;
            else if (vcnt_d < V_BP_BEG) v_state = V_SY;
            else                        v_state = V_BP;

            pix_tick_d    = 1'b1;
            hsync_d       = (h_state == H_SY) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (v_state == V_SY) ? VSYNC_POL : ~VSYNC_POL;
            visible_d     = (h_state == H_ACT) && (v_state == V_ACT);
            x_d           = visible_d ? hcnt_d : '0;
            y_d           = visible_d ? vcnt_d : '0;
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && (vcnt_d == '0);
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            visible_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pix_tick_q    <= pix_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign oPixelTick  = pix_tick_q;
    assign oHSync      = hsync_q;
    assign oVSync      = vsync_q;
    assign oVisible    = visible_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oLineStart  = line_start_q;
    assign oFrameStart = frame_start_q;

endmodule
`default_nettype wire
